// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared Game Boy bus constants and OAM DMA state encoding
package gb_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } dma_state_t;

    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam logic [15:0] DMA_REG     = 16'hFF46;
    localparam logic [7:0]  ECHO_LO     = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET = 8'h20;

endpackage

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA bus initiator with CPU-visible trigger/source register
module oam_dma
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] REG_ADDR  = DMA_REG,
    parameter logic [15:0] DEST_BASE = OAM_BASE,
    parameter int          LENGTH    = 160
) (
    input  logic        clockgb,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_indata,
    input  logic        cpu_load,
    input  logic        cpu_store,
    output logic [7:0]  cpu_outdata,
    output logic [15:0] dma_address,
    output logic [7:0]  dma_outdata,
    input  logic [7:0]  dma_indata,
    output logic        dma_load,
    output logic        dma_store,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

    dma_state_t state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] index_q, index_d;
    logic [7:0] buffer_q, buffer_d;
    logic [7:0] rdata_q, rdata_d;
    logic       reg_sel;
    logic       trigger;
    logic [7:0] src_eff;

    assign reg_sel     = (cpu_address == REG_ADDR);
    assign trigger     = cpu_store && reg_sel;
    assign cpu_outdata = rdata_q;
    // Echo RAM E000-FDFF mirrors C000-DDFF, so fold the page down.
    assign src_eff     = (src_q < ECHO_LO) ? src_q : (src_q - ECHO_OFFSET);

    always_ff @(posedge clockgb) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            src_q    <= 8'h00;
            index_q  <= 8'h00;
            buffer_q <= 8'h00;
            rdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            index_q  <= index_d;
            buffer_q <= buffer_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        index_d     = index_q;
        buffer_d    = buffer_q;
        rdata_d     = (cpu_load && reg_sel) ? src_q : 8'h00;
        dma_address = 16'h0000;
        dma_outdata = 8'h00;
        dma_load    = 1'b0;
        dma_store   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_START: begin
                busy    = 1'b1;
                state_d = ST_READ;
            end
            ST_READ: begin
                busy        = 1'b1;
                dma_load    = 1'b1;
                dma_address = {src_eff, index_q};
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                busy        = 1'b1;
                dma_address = {src_eff, index_q};
                buffer_d    = dma_indata;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                busy        = 1'b1;
                dma_store   = 1'b1;
                dma_address = DEST_BASE + {8'h00, index_q};
                dma_outdata = buffer_q;
                if (index_q == LAST_INDEX) begin
                    state_d = ST_DONE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = ST_READ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A retrigger overrides whatever the sequencer chose; the current
        // cycle's strobes above still go out unchanged.
        if (trigger) begin
            src_d   = cpu_indata;
            index_d = 8'h00;
            state_d = ST_START;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for oam_dma with a one-cycle-latency memory model
module tb_oam_dma;

    logic        clockgb = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_address = 16'h0000;
    logic [7:0]  cpu_indata = 8'h00;
    logic        cpu_load = 1'b0;
    logic        cpu_store = 1'b0;
    logic [7:0]  cpu_outdata;
    logic [15:0] dma_address;
    logic [7:0]  dma_outdata;
    logic [7:0]  dma_indata = 8'h00;
    logic        dma_load;
    logic        dma_store;
    logic        busy;
    logic        done;

    oam_dma dut (
        .clockgb     (clockgb),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_indata  (cpu_indata),
        .cpu_load    (cpu_load),
        .cpu_store   (cpu_store),
        .cpu_outdata (cpu_outdata),
        .dma_address (dma_address),
        .dma_outdata (dma_outdata),
        .dma_indata  (dma_indata),
        .dma_load    (dma_load),
        .dma_store   (dma_store),
        .busy        (busy),
        .done        (done)
    );

    always #5 clockgb = ~clockgb;

    logic [7:0]  mem [0:65535];
    logic [23:0] exp_q [$];
    int checks = 0;
    int passed = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    always @(posedge clockgb) begin
        if (dma_load) dma_indata <= mem[dma_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every store the DUT presents is matched against the queue.
    always @(negedge clockgb) begin
        logic [23:0] e;
        if (dma_load && dma_store) check("strobe_overlap", 32'd1, 32'd0);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (dma_store) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {8'h00, dma_address, dma_outdata}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check("write", {8'h00, dma_address, dma_outdata}, {8'h00, e});
            end
        end
    end

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clockgb);
        cpu_address = a;
        cpu_indata  = d;
        cpu_store   = 1'b1;
        @(posedge clockgb);
        #1;
        cpu_store   = 1'b0;
        cpu_address = 16'h0000;
    endtask

    task automatic push_run(input logic [7:0] key, input int first, input int count);
        for (int i = first; i < first + count; i++)
            exp_q.push_back({16'hFE00 + 16'(i), 8'(i) ^ key});
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clockgb);
            n++;
        end while (!done && n < 2000);
        check("done_timeout", {31'd0, done}, 32'd1);
        @(posedge clockgb);
        #1;
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_cnt < target && n < 2000) begin
            @(negedge clockgb);
            #1;
            n++;
        end
        check("write_count_reached", wr_cnt, target);
    endtask

    initial begin
        int b0, d0, w0;
        logic ok;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8);
        for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;

        repeat (3) @(posedge clockgb);
        #1 reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clockgb);
            check("idle_outputs", {cpu_outdata, dma_address, dma_outdata, dma_load, dma_store, busy, done}, 0);
        end

        // C1 transfer: latency, ordering, busy length, single done
        push_run(8'h5A, 0, 160);
        b0 = busy_cnt; d0 = done_cnt;
        cpu_write(16'hFF46, 8'hC1);
        @(negedge clockgb);
        check("start_no_load", {30'd0, dma_load, busy}, 32'd1);
        @(negedge clockgb);
        check("first_load", {15'd0, dma_load, dma_address}, {15'd0, 1'b1, 16'hC100});
        wait_done();
        check("busy_cycles", busy_cnt - b0, 481);
        check("done_pulses_c1", done_cnt - d0, 1);
        check("queue_drained_c1", exp_q.size(), 0);

        // E3 folds to C3: mem[C3xx] = i ^ C3, mem[E3xx] would be i ^ E3
        push_run(8'hC3, 0, 160);
        cpu_write(16'hFF46, 8'hE3);
        @(negedge clockgb);
        @(negedge clockgb);
        check("echo_first_load", dma_address, 16'hC300);
        wait_done();
        check("queue_drained_e3", exp_q.size(), 0);

        // Retrigger with D0 during the WRITE of byte 39
        push_run(8'h5A, 0, 40);
        push_run(8'hD0, 0, 160);
        d0 = done_cnt; w0 = wr_cnt;
        cpu_write(16'hFF46, 8'hC1);
        wait_writes(w0 + 40);
        cpu_address = 16'hFF46;
        cpu_indata  = 8'hD0;
        cpu_store   = 1'b1;
        @(posedge clockgb);
        #1;
        cpu_store   = 1'b0;
        cpu_address = 16'h0000;
        wait_done();
        check("done_pulses_retrigger", done_cnt - d0, 1);
        check("queue_drained_retrigger", exp_q.size(), 0);

        // Reset during WAIT of index 77 (0x4D)
        push_run(8'h5A, 0, 77);
        d0 = done_cnt; w0 = wr_cnt;
        cpu_write(16'hFF46, 8'hC1);
        wait_writes(w0 + 77);
        @(posedge clockgb);
        @(posedge clockgb);
        #1;
        check("wait_cycle", {14'd0, dma_load, dma_store, dma_address}, {16'd0, 16'hC14D});
        reset = 1'b1;
        @(posedge clockgb);
        #1 reset = 1'b0;
        @(negedge clockgb);
        check("after_reset_outputs", {cpu_outdata, dma_address, dma_outdata, dma_load, dma_store, busy, done}, 0);
        repeat (20) @(negedge clockgb);
        check("writes_after_reset", wr_cnt - w0, 77);
        check("done_after_reset", done_cnt - d0, 0);
        check("queue_drained_reset", exp_q.size(), 0);

        // Store to another address is ignored
        cpu_write(16'hFF47, 8'h55);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clockgb);
            if (busy || dma_load) ok = 1'b0;
        end
        check("other_addr_ignored", {31'd0, ok}, 32'd1);

        // Readback: 9A then 0 for an unselected load
        push_run(8'h9A, 0, 160);
        cpu_write(16'hFF46, 8'h9A);
        cpu_address = 16'hFF46;
        cpu_load    = 1'b1;
        @(posedge clockgb);
        #1;
        check("readback_ff46", cpu_outdata, 8'h9A);
        cpu_address = 16'hFF47;
        @(posedge clockgb);
        #1;
        check("readback_ff47", cpu_outdata, 8'h00);
        cpu_load    = 1'b0;
        cpu_address = 16'h0000;
        @(posedge clockgb);
        #1;
        check("readback_idle", cpu_outdata, 8'h00);
        wait_done();
        check("queue_drained_9a", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
